// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN to honour is_signed (adds the FIX sign-correction state).
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient_hi,
  output logic [WIDTH-1:0] quotient_lo
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dd_q, dd_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dbz_q, dbz_d;
  logic             signed_op, neg_dd, neg_dv, accept, fits;
  logic [WIDTH-1:0] mag_dd, mag_dv, dd_nx;
  logic [WIDTH:0]   rem_sh, trial, rem_nx;
`ifdef DIV_SIGNED_EN
  logic             sq_q, sq_d, sr_q, sr_d;
`endif
  always_comb begin
`ifdef DIV_SIGNED_EN
    signed_op = is_signed;
`else
    signed_op = is_signed & 1'b0;
`endif
    neg_dd = signed_op & dividend[WIDTH-1];
    neg_dv = signed_op & divisor[WIDTH-1];
    // the most negative value negates to itself, which is its correct unsigned magnitude
    mag_dd = neg_dd ? -dividend : dividend;
    mag_dv = neg_dv ? -divisor : divisor;
    accept = (state_q == IDLE || state_q == DONE) && start;
    rem_sh = {rem_q, dd_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dv_q};
    fits   = !trial[WIDTH];
    rem_nx = fits ? trial : rem_sh;
    dd_nx  = {dd_q[WIDTH-2:0], fits};
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dd_d    = dd_q;
    dv_d    = dv_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    sq_d = sq_q;
    sr_d = sr_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = !start ? IDLE : (divisor == '0) ? DONE : CALC;
        if (accept) begin
          dd_d  = mag_dd;
          dv_d  = mag_dv;
          rem_d = '0;
          cnt_d = '0;
`ifdef DIV_SIGNED_EN
          sq_d = neg_dd ^ neg_dv;
          sr_d = neg_dd;
`endif
          if (divisor == '0) begin
            lo_d  = '1;
            hi_d  = dividend;
            dbz_d = 1'b1;
          end
        end
      end
      CALC: begin
        rem_d = rem_nx[WIDTH-1:0];
        dd_d  = dd_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
`ifdef DIV_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
          lo_d    = dd_nx;
          hi_d    = rem_nx[WIDTH-1:0];
          dbz_d   = 1'b0;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      FIX: begin
        state_d = DONE;
        lo_d    = sq_q ? -dd_q : dd_q;
        hi_d    = sr_q ? -rem_q : rem_q;
        dbz_d   = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dd_q    <= '0;
      dv_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dd_q    <= dd_d;
      dv_q    <= dv_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dbz_q   <= dbz_d;
    end
  end
`ifdef DIV_SIGNED_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sq_q <= 1'b0;
      sr_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
      sr_q <= sr_d;
    end
  end
`endif
  assign busy        = state_q == CALC || state_q == FIX;
  assign done        = state_q == DONE;
  assign div_by_zero = dbz_q;
  assign quotient_hi = hi_q;
  assign quotient_lo = lo_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with a queue scoreboard; a forked monitor checks every done pulse.
module tb_seq_divider;
`ifdef DIV_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif
  logic        Clock = 1'b0, Reset = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient_hi, quotient_lo;
  int cyc = 0;
  int pass = 0, total = 0;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          at;
  } exp_t;
  exp_t sb[$];

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .quotient_hi(quotient_hi), .quotient_lo(quotient_lo)
  );

  initial forever #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, want, $time);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge Clock);
      if (sb.size() != 0 && cyc > sb[0].at) begin
        e = sb.pop_front();
        total++;
        $display("FAIL missing_done: no done by cycle %0d, expected lo=0x%08h", e.at, e.lo);
      end
      if (!Reset && done) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: lo=0x%08h hi=0x%08h at cycle %0d", quotient_lo, quotient_hi, cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient_lo", quotient_lo, e.lo);
          chk("quotient_hi", quotient_hi, e.hi);
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
          chk("latency_cycle", cyc, e.at);
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
    end
  endtask

  task automatic issue(input logic [31:0] dd, input logic [31:0] dv, input logic sg,
                       input logic [31:0] lo, input logic [31:0] hi, input logic dbz, input int lat);
    dividend  = dd;
    divisor   = dv;
    is_signed = sg;
    start     = 1'b1;
    sb.push_back('{lo: lo, hi: hi, dbz: dbz, at: cyc + lat});
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * LAT && sb.size() != 0; i++) @(negedge Clock);
    @(negedge Clock);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
    chk({tag, "_hi"}, quotient_hi, 32'd0);
    chk({tag, "_lo"}, quotient_lo, 32'd0);
  endtask

  initial begin
    int c;
    fork monitor(); join_none
    repeat (2) @(negedge Clock);
    chk_zero("reset");
    Reset = 1'b0;
    @(negedge Clock);
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, LAT);
    chk("busy_in_calc", {31'd0, busy}, 32'd1);
    drain();
    issue(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    drain();
`ifdef DIV_SIGNED_EN
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT);
    drain();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, LAT);
    drain();
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, LAT);
    drain();
    issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, LAT);
    drain();
`else
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, LAT);
    drain();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, LAT);
    drain();
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0, LAT);
    drain();
    issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd0, 32'hFFFF_FF9C, 1'b0, LAT);
    drain();
`endif
    issue(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
    drain();
    issue(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, LAT);
    drain();
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT);
    drain();
    // abort mid-calculation: nothing is queued, so any later done would be flagged
    dividend = 32'h0001_2345;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    repeat (9) @(negedge Clock);
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    Reset = 1'b1;
    #1;
    chk_zero("abort");
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    issue(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, LAT);
    drain();
    c = cyc;
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    sb.push_back('{lo: 32'd14, hi: 32'd2, dbz: 1'b0, at: c + LAT});
    sb.push_back('{lo: 32'd3, hi: 32'd0, dbz: 1'b0, at: c + 2 * LAT});
    @(negedge Clock);
    dividend = 32'd9;
    divisor  = 32'd3;
    while (cyc < c + LAT + 1) @(negedge Clock);
    chk("busy_second_op", {31'd0, busy}, 32'd1);
    start = 1'b0;
    drain();
    repeat (3) @(negedge Clock);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
